// File: rtl/score_arbiter_pkg.sv
// Shared definitions for the scoring arbiter and the blocks
// (display, game control) that read its state and score.
package score_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam int SCORE_W       = 7;
  localparam int SCORE_MAX_DEF = 99;

  function automatic logic [SCORE_W-1:0] sat_inc(
    input logic [SCORE_W-1:0] s,
    input logic [SCORE_W-1:0] mx
  );
    return (s >= mx) ? mx : s + 7'd1;
  endfunction

endpackage

// File: rtl/score_arbiter_rr.sv
// Round-robin picker: first eligible requester at or after ptr,
// wrapping, plus the pointer that follows the winner.
module rr_arbiter
  import score_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  elig,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          hit,
  output logic [PW-1:0] ptr_nxt
);

  logic [PW-1:0] sel;

  always_comb begin
    gnt     = '0;
    hit     = 1'b0;
    ptr_nxt = ptr;
    sel     = '0;
    for (int k = 0; k < N; k++) begin
      sel = PW'((int'(ptr) + k) % N);
      if (!hit && elig[sel]) begin
        hit      = 1'b1;
        gnt[sel] = 1'b1;
        ptr_nxt  = PW'((int'(sel) + 1) % N);
      end
    end
  end

endmodule

// File: rtl/score_arbiter.sv
// Round-timed score arbiter: grants one requester per edge and
// counts grants made during a play round toward the score.
module score_arbiter
  import score_arbiter_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int ROUND_CYCLES = 1000,
  parameter int SCORE_MAX    = SCORE_MAX_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [N_REQ-1:0]                req,
  output logic [N_REQ-1:0]                ack,
  output logic                            score_flag,
  output logic [SCORE_W-1:0]              score,
  output logic [SCORE_W-1:0]              high_score,
  output logic [$clog2(ROUND_CYCLES)-1:0] time_left,
  output logic [1:0]                      state
);

  localparam int TW = $clog2(ROUND_CYCLES);
  localparam int PW = $clog2(N_REQ);
  localparam logic [TW-1:0] T_LOAD = TW'(ROUND_CYCLES - 1);
  localparam logic [SCORE_W-1:0] SMAX = SCORE_W'(SCORE_MAX);

  state_t               st, st_nxt;
  logic                 enter_play;
  logic [N_REQ-1:0]     elig, gnt;
  logic                 gnt_any;
  logic [PW-1:0]        ptr, ptr_nxt;
  logic [SCORE_W-1:0]   score_inc, final_score;

  // a requester still holding req during its ack cycle is masked
  assign elig = req & ~ack;

  rr_arbiter #(
    .N  (N_REQ),
    .PW (PW)
  ) u_rr (
    .elig    (elig),
    .ptr     (ptr),
    .gnt     (gnt),
    .hit     (gnt_any),
    .ptr_nxt (ptr_nxt)
  );

  always_comb begin
    st_nxt     = st;
    enter_play = 1'b0;
    case (st)
      IDLE, OVER: begin
        if (start) begin
          st_nxt     = PLAY;
          enter_play = 1'b1;
        end
      end
      PLAY: begin
        if (time_left == '0) st_nxt = OVER;
      end
      default: st_nxt = IDLE;
    endcase
  end

  assign score_inc   = sat_inc(score, SMAX);
  assign final_score = gnt_any ? score_inc : score;

  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= IDLE;
      ack        <= '0;
      ptr        <= '0;
      score_flag <= 1'b0;
      score      <= '0;
      high_score <= '0;
      time_left  <= '0;
    end else begin
      st         <= st_nxt;
      ack        <= gnt;
      ptr        <= ptr_nxt;
      score_flag <= 1'b0;
      // a new round wins over a same-edge grant from OVER
      if (enter_play) begin
        score     <= '0;
        time_left <= T_LOAD;
      end else if (st == PLAY) begin
        if (gnt_any) begin
          score      <= score_inc;
          score_flag <= 1'b1;
        end
        if (time_left != '0)
          time_left <= time_left - TW'(1);
        else if (final_score > high_score)
          high_score <= final_score;
      end
    end
  end

  assign state = st;

endmodule

// File: tb/tb_score_arbiter.sv
// Directed bench for score_arbiter: stimulus queues expected grants,
// a forked monitor pops and compares whenever ack is presented.
module tb_score_arbiter;

  localparam int N  = 4;
  localparam int RC = 120;
  localparam int SM = 99;
  localparam int TW = $clog2(RC);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [N-1:0]  req;
  logic [N-1:0]  ack;
  logic          score_flag;
  logic [6:0]    score;
  logic [6:0]    high_score;
  logic [TW-1:0] time_left;
  logic [1:0]    state;

  score_arbiter #(
    .N_REQ        (N),
    .ROUND_CYCLES (RC),
    .SCORE_MAX    (SM)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .req        (req),
    .ack        (ack),
    .score_flag (score_flag),
    .score      (score),
    .high_score (high_score),
    .time_left  (time_left),
    .state      (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int flag;
    int sc;
  } exp_t;

  exp_t         q[$];
  int           checks = 0;
  int           fails  = 0;
  bit           hold_all = 1'b0;
  logic [N-1:0] ack_d = '0;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic push(input int i, input int f, input int s);
    exp_t e;
    e.idx  = i;
    e.flag = f;
    e.sc   = s;
    q.push_back(e);
  endtask

  // requesters drop req one cycle after seeing their ack
  task automatic step();
    @(posedge clk);
    #1;
    if (!hold_all) req = req & ~ack_d;
    ack_d = ack;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (ack != '0) begin
        if (q.size() == 0) begin
          check("sb_unexpected_ack", int'(ack), 0);
        end else begin
          e = q.pop_front();
          check("sb_ack", int'(ack), 1 << e.idx);
          check("sb_flag", int'(score_flag), e.flag);
          check("sb_score", int'(score), e.sc);
        end
      end else begin
        check("flag_without_ack", int'(score_flag), 0);
      end
    end
  endtask

  task automatic wait_over();
    for (int i = 0; i < RC + 10; i++) begin
      if (state == 2'd2) break;
      step();
    end
    check("reach_over", int'(state), 2);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_state"}, int'(state), 0);
    check({tag, "_score"}, int'(score), 0);
    check({tag, "_high"}, int'(high_score), 0);
    check({tag, "_tl"}, int'(time_left), 0);
    check({tag, "_ack"}, int'(ack), 0);
    check({tag, "_flag"}, int'(score_flag), 0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    req   = '0;
    fork
      monitor();
    join_none

    step();
    step();
    check_reset("rst0");
    rst = 1'b0;

    // round 1: single requester, masking, pointer after grant 2
    start = 1'b1;
    step();
    start = 1'b0;
    check("r1_state", int'(state), 1);
    check("r1_tl_load", int'(time_left), RC - 1);
    check("r1_score0", int'(score), 0);
    req = 4'b0100;
    push(2, 1, 1);
    step();
    check("a_score", int'(score), 1);
    check("a_flag", int'(score_flag), 1);
    step();
    check("a_masked", int'(ack), 0);
    req = 4'b1001;
    push(3, 1, 2);
    push(0, 1, 3);
    repeat (3) step();
    check("a_score3", int'(score), 3);

    // grant on the edge that sees time_left==0
    for (int i = 0; i < RC + 10; i++) begin
      if (time_left == TW'(1)) break;
      step();
    end
    check("tl_one", int'(time_left), 1);
    req = 4'b0010;
    push(1, 1, 4);
    step();
    check("tl_zero_play", int'(state), 1);
    check("tl_zero", int'(time_left), 0);
    req = req | 4'b1000;
    push(3, 1, 5);
    step();
    check("end1_state", int'(state), 2);
    check("end1_score", int'(score), 5);
    check("end1_high", int'(high_score), 5);
    check("end1_tl", int'(time_left), 0);

    // drain in OVER without scoring
    req = req | 4'b0100;
    push(2, 0, 5);
    step();
    step();
    check("over_score", int'(score), 5);
    check("over_state", int'(state), 2);

    // round 2 scores 3; best stays 5
    start = 1'b1;
    step();
    start = 1'b0;
    check("r2_clear", int'(score), 0);
    req = 4'b0111;
    push(0, 1, 1);
    push(1, 1, 2);
    push(2, 1, 3);
    repeat (4) step();
    wait_over();
    check("end2_score", int'(score), 3);
    check("end2_high", int'(high_score), 5);

    // start and grant on the same edge from OVER
    start = 1'b1;
    req   = 4'b0001;
    push(0, 0, 0);
    step();
    start = 1'b0;
    check("r3_state", int'(state), 1);
    check("r3_score", int'(score), 0);

    // round 3: all requesters held, rotation and saturation
    hold_all = 1'b1;
    req      = 4'b1111;
    for (int g = 0; g < 105; g++)
      push((1 + g) % 4, 1, (g + 1 > SM) ? SM : g + 1);
    repeat (105) step();
    req      = '0;
    hold_all = 1'b0;
    check("sat_score", int'(score), SM);
    check("sat_tl", int'(time_left), RC - 1 - 105);
    wait_over();
    check("end3_high", int'(high_score), SM);

    // round 4: reset mid-play with score 7 and req[1] held
    start = 1'b1;
    step();
    start    = 1'b0;
    hold_all = 1'b1;
    req      = 4'b1111;
    for (int g = 0; g < 7; g++)
      push((2 + g) % 4, 1, g + 1);
    repeat (7) step();
    check("pre_rst_score", int'(score), 7);
    hold_all = 1'b0;
    req      = 4'b0010;
    rst      = 1'b1;
    step();
    check_reset("rst1");
    step();
    check("rst_hold_ack", int'(ack), 0);
    rst = 1'b0;
    push(1, 0, 0);
    step();
    check("post_rst_ack", int'(ack), 2);
    check("post_rst_score", int'(score), 0);
    repeat (4) step();
    check("sb_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
